// File: rtl/fetch_if.sv
// ============================================================================
// Module   : fetch_if
// Brief    : Instruction-bus and decode-side signals of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    input  imem_ack_i, imem_data_i, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    output imem_ack_i, imem_data_i, stall_i, redirect_i, redirect_pc_i
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner and instruction fetch with skid buffer and redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00010000
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  fetch_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [31:0] C_RESET_ADDR = RESET_PC & ~32'h3;

  state_t      r_state;
  logic [31:0] req_addr_q;
  logic [31:0] tgt_q;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_valid;

  logic        w_out_free;
  logic [31:0] w_redirect_tgt;

  assign w_out_free     = !r_valid || !bus.stall_i;
  assign w_redirect_tgt = bus.redirect_pc_i & ~32'h3;

  // Request is a pure decode of the state register, never of the ack.
  assign bus.imem_req_o    = (r_state == ST_FETCH) || (r_state == ST_FLUSH);
  assign bus.imem_addr_o   = req_addr_q;
  assign bus.instr_o       = r_instr;
  assign bus.pc_o          = r_pc;
  assign bus.instr_valid_o = r_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      req_addr_q <= C_RESET_ADDR;
      tgt_q      <= 32'h0;
      r_instr    <= 32'h0;
      r_pc       <= 32'h0;
      r_valid    <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      skid_valid <= 1'b0;
    end else if (bus.redirect_i) begin
      r_valid    <= 1'b0;
      skid_valid <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // Without an ack the old request must finish before the new one.
          if (bus.imem_ack_i) begin
            req_addr_q <= w_redirect_tgt;
          end else begin
            tgt_q   <= w_redirect_tgt;
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          tgt_q <= w_redirect_tgt;
          if (bus.imem_ack_i) begin
            req_addr_q <= w_redirect_tgt;
            r_state    <= ST_FETCH;
          end
        end
        default: begin
          req_addr_q <= w_redirect_tgt;
          r_state    <= ST_FETCH;
        end
      endcase
    end else begin
      if (!bus.stall_i) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.imem_ack_i) begin
            req_addr_q <= req_addr_q + 32'd4;
            if (w_out_free) begin
              r_instr <= bus.imem_data_i;
              r_pc    <= req_addr_q;
              r_valid <= 1'b1;
            end else begin
              skid_instr <= bus.imem_data_i;
              skid_pc    <= req_addr_q;
              skid_valid <= 1'b1;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.stall_i) begin
            r_instr    <= skid_instr;
            r_pc       <= skid_pc;
            r_valid    <= skid_valid;
            skid_valid <= 1'b0;
            r_state    <= ST_FETCH;
          end
        end
        ST_FLUSH: begin
          if (bus.imem_ack_i) begin
            req_addr_q <= tgt_q;
            r_state    <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic clk;
  logic rst_ni;
  int   checks;
  int   failures;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h00010000)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.imem_ack_i = 1'b0; bus.imem_data_i = 32'h0; bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
    checks++; if (bus.imem_addr_o !== 32'h00010000) begin failures++; $display("FAIL reset_addr: got %h want 00010000", bus.imem_addr_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", bus.instr_o); end
    checks++; if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", bus.pc_o); end
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = 32'h00010000 + 32'(4 * i);
      checks++; if (bus.imem_req_o !== 1'b1) begin failures++; $display("FAIL stream_req[%0d]: got %b want 1", i, bus.imem_req_o); end
      checks++; if (bus.imem_addr_o !== e) begin failures++; $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.imem_addr_o, e); end
      checks++; if (bus.instr_valid_o !== (i > 0)) begin failures++; $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.instr_valid_o, (i > 0)); end
      if (i > 0) begin
        checks++; if (bus.instr_o !== e - 32'd4) begin failures++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.instr_o, e - 32'd4); end
        checks++; if (bus.pc_o !== e - 32'd4) begin failures++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.pc_o, e - 32'd4); end
      end
      bus.imem_ack_i = 1'b1; bus.imem_data_i = e;
    end
  endtask

  task automatic test_stall_skid();
    @(negedge clk);
    bus.stall_i = 1'b1; bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h00010018;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.imem_ack_i = 1'b0;
      checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL hold_req[%0d]: got %b want 0", i, bus.imem_req_o); end
      checks++; if (bus.instr_o !== 32'h00010014 || bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL hold_out[%0d]: got %h/%b want 00010014/1", i, bus.instr_o, bus.instr_valid_o); end
      checks++; if (bus.imem_addr_o !== 32'h0001001C) begin failures++; $display("FAIL hold_addr[%0d]: got %h want 0001001c", i, bus.imem_addr_o); end
    end
    bus.stall_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.instr_o !== 32'h00010018 || bus.pc_o !== 32'h00010018 || bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL skid_out: got %h/%h/%b want 00010018/00010018/1", bus.instr_o, bus.pc_o, bus.instr_valid_o); end
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0001001C) begin failures++; $display("FAIL skid_req: got %b/%h want 1/0001001c", bus.imem_req_o, bus.imem_addr_o); end
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h0001001C;
    @(negedge clk);
    checks++; if (bus.instr_o !== 32'h0001001C || bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL after_skid: got %h/%b want 0001001c/1", bus.instr_o, bus.instr_valid_o); end
    checks++; if (bus.imem_addr_o !== 32'h00010020) begin failures++; $display("FAIL after_skid_addr: got %h want 00010020", bus.imem_addr_o); end
    bus.imem_ack_i = 1'b0;
  endtask

  task automatic test_redirect_wait();
    @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h00010020 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL wait_pre: got %h/%b want 00010020/0", bus.imem_addr_o, bus.instr_valid_o); end
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h00020002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.redirect_i = 1'b0;
      checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h00010020) begin failures++; $display("FAIL flush_addr[%0d]: got %b/%h want 1/00010020", i, bus.imem_req_o, bus.imem_addr_o); end
      checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid[%0d]: got %b want 0", i, bus.instr_valid_o); end
    end
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'hDEAD0000;
    @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h00020000 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL wait_newreq: got %h/%b want 00020000/0", bus.imem_addr_o, bus.instr_valid_o); end
    bus.imem_data_i = 32'h00020000;
    @(negedge clk);
    checks++; if (bus.instr_o !== 32'h00020000 || bus.pc_o !== 32'h00020000 || bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL wait_newword: got %h/%h/%b want 00020000/00020000/1", bus.instr_o, bus.pc_o, bus.instr_valid_o); end
    bus.imem_ack_i = 1'b0;
  endtask

  task automatic test_redirect_ack_stall();
    @(negedge clk);
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h00020004;
    @(negedge clk);
    checks++; if (bus.instr_o !== 32'h00020004 || bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL ras_full: got %h/%b want 00020004/1", bus.instr_o, bus.instr_valid_o); end
    bus.imem_data_i = 32'h00020008; bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h00000300;
    @(negedge clk);
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL ras_valid: got %b want 0", bus.instr_valid_o); end
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h00000300) begin failures++; $display("FAIL ras_addr: got %b/%h want 1/00000300", bus.imem_req_o, bus.imem_addr_o); end
    bus.redirect_i = 1'b0; bus.stall_i = 1'b0; bus.imem_ack_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h00000300 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL ras_hold: got %h/%b want 00000300/0", bus.imem_addr_o, bus.instr_valid_o); end
  endtask

  task automatic test_wrap_redirects();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFFFFFC;
    @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h00000300) begin failures++; $display("FAIL b2b_first: got %h want 00000300", bus.imem_addr_o); end
    bus.redirect_pc_i = 32'h00000040;
    @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h00000300 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_second: got %h/%b want 00000300/0", bus.imem_addr_o, bus.instr_valid_o); end
    bus.redirect_i = 1'b0; bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h00000BAD;
    @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h00000040 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_latest: got %h/%b want 00000040/0", bus.imem_addr_o, bus.instr_valid_o); end
    bus.imem_data_i = 32'h00000040;
    @(negedge clk);
    checks++; if (bus.instr_o !== 32'h00000040 || bus.instr_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h00000044) begin failures++; $display("FAIL b2b_word: got %h/%b/%h want 00000040/1/00000044", bus.instr_o, bus.instr_valid_o, bus.imem_addr_o); end
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFFFFFC; bus.imem_data_i = 32'h0000BEEF;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    checks++; if (bus.imem_addr_o !== 32'hFFFFFFFC || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL wrap_req: got %h/%b want fffffffc/0", bus.imem_addr_o, bus.instr_valid_o); end
    bus.imem_data_i = 32'h12345678;
    @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h00000000) begin failures++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_addr_o); end
    checks++; if (bus.instr_o !== 32'h12345678 || bus.pc_o !== 32'hFFFFFFFC || bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL wrap_word: got %h/%h/%b want 12345678/fffffffc/1", bus.instr_o, bus.pc_o, bus.instr_valid_o); end
    bus.imem_data_i = 32'h00009ABC;
    @(negedge clk);
    checks++; if (bus.pc_o !== 32'h00000000 || bus.instr_o !== 32'h00009ABC || bus.imem_addr_o !== 32'h00000004) begin failures++; $display("FAIL wrap_next: got %h/%h/%h want 00000000/00009abc/00000004", bus.pc_o, bus.instr_o, bus.imem_addr_o); end
    bus.imem_ack_i = 1'b0;
  endtask

  task automatic test_async_reset_hold();
    @(negedge clk);
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h00000004;
    @(negedge clk);
    bus.stall_i = 1'b1; bus.imem_data_i = 32'h00000008;
    @(negedge clk);
    bus.imem_ack_i = 1'b0;
    checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h00000004) begin failures++; $display("FAIL pre_rst_hold: got %b/%b/%h want 0/1/00000004", bus.imem_req_o, bus.instr_valid_o, bus.instr_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL async_rst: got %b/%b want 0/0", bus.imem_req_o, bus.instr_valid_o); end
    checks++; if (bus.imem_addr_o !== 32'h00010000) begin failures++; $display("FAIL async_rst_addr: got %h want 00010000", bus.imem_addr_o); end
    @(negedge clk);
    rst_ni = 1'b1; bus.stall_i = 1'b0;
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h0BAD0BAD;
    @(negedge clk);
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h00010000 || bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL restart_req: got %b/%h/%b want 1/00010000/0", bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o); end
    bus.imem_data_i = 32'hA5A50000;
    @(negedge clk);
    checks++; if (bus.instr_o !== 32'hA5A50000 || bus.pc_o !== 32'h00010000 || bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL restart_word: got %h/%h/%b want a5a50000/00010000/1", bus.instr_o, bus.pc_o, bus.instr_valid_o); end
    bus.imem_ack_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_ack_stall();
    test_wrap_redirects();
    test_async_reset_hold();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
